// File: rtl/nibble_add_seq.sv
// Sequential WIDTH-bit adder built on one shared 4-bit slice, one nibble per cycle, LSB first.
// Optional subtract mode is enabled by defining NIBBLE_ADD_SEQ_SUB_EN (adds the sub input).
module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int SW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSLICE - 1);

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
      $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_cap;
  logic             carry;
  logic             carry_init;
  logic [SW-1:0]    step;
  logic [WIDTH:0]   res_q;
  logic [4:0]       s;
  logic [WIDTH+3:0] res_shift;
  logic             accept;
  logic             last;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
  assign b_cap      = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_cap      = b;
  assign carry_init = 1'b0;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign last      = (step == LAST_STEP);
  assign s         = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
  assign res_shift = {s[3:0], res_q[WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      step  <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b_cap;
            carry <= carry_init;
            step  <= '0;
          end
        end
        RUN: begin
          // New nibble enters at the top; after NSLICE steps the sum is aligned at bit 0.
          res_q[WIDTH-1:0] <= res_shift[WIDTH+3:4];
          carry            <= s[4];
          a_sh             <= a_sh >> 4;
          b_sh             <= b_sh >> 4;
          step             <= last ? '0 : step + SW'(1);
          if (last) res_q[WIDTH] <= s[4];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: transaction-level reference model checked every cycle,
// plus literal expectations for the hand-computed vectors.
module tb_nibble_add_seq;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic           sub = 1'b0;
`endif
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W:0]     result;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: transaction-level timing and plain arithmetic
  logic [W:0] exp_q[$];
  bit         m_idle = 1'b1;
  bit         m_done = 1'b0;
  int         m_left = 0;
  logic [W:0] m_res  = '0;

  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit do_sub);
    logic [W-1:0] d;
    if (do_sub) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_left = 0;
      m_res  = '0;
      exp_q.delete();
    end else if (m_idle) begin
      if (in_valid) begin
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        exp_q.push_back(ref_result(a_i, b_i, sub));
`else
        exp_q.push_back(ref_result(a_i, b_i, 1'b0));
`endif
        m_idle = 1'b0;
        m_left = NSLICE;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_res  = exp_q.pop_front();
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  // scoreboard compare, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_idle));
      check("out_valid", 64'(out_valid), 64'(m_done));
      check("busy", 64'(busy), 64'(!m_idle));
      if (m_done && exp_q.size() > 0) check("result_done", 64'(result), 64'(exp_q[0]));
      else if (m_idle) check("result_hold", 64'(result), 64'(m_res));
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    t = 0;
    while (!in_ready && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    check("issue_ready_timeout", 64'(in_ready), 64'(1));
    a_i = x;
    b_i = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int    lat;
  bit    ov_seen;
  time   acc_t[3];
  logic [W-1:0] bb_a[3] = '{16'h8000, 16'h1111, 16'hFFFF};
  logic [W-1:0] bb_b[3] = '{16'h8000, 16'h2222, 16'hFFFF};

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // basic add and latency
    issue(16'h1234, 16'h4321);
    wait_done(lat);
    check("lat_1234", 64'(lat), 64'(NSLICE));
    check("sum_1234", 64'(result), 64'h05555);
    @(posedge clk); #1;
    check("ready_after_done", 64'(in_ready), 64'(1));
    check("valid_after_done", 64'(out_valid), 64'(0));

    // carry across every nibble
    issue(16'hFFFF, 16'h0001);
    wait_done(lat);
    check("sum_wrap", 64'(result), 64'h10000);
    @(posedge clk); #1;

    // consumer stall, with ignored producer traffic
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h00F1);
    wait_done(lat);
    check("sum_stall", 64'(result), 64'h01000);
    for (int i = 0; i < 5; i++) begin
      a_i = 16'h1111;
      b_i = 16'h2222;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_ready", 64'(in_ready), 64'(0));
      check("stall_result", 64'(result), 64'h01000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", 64'(in_ready), 64'(1));

    // reset in the second RUN cycle aborts the operation
    issue(16'hAAAA, 16'h5555);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("abort_no_pulse", 64'(ov_seen), 64'(0));
    issue(16'h0001, 16'h0001);
    wait_done(lat);
    check("sum_after_abort", 64'(result), 64'h00002);
    @(posedge clk); #1;

    // back-to-back issue with in_valid held high
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_i = bb_a[i];
      b_i = bb_b[i];
      for (int t = 0; t < 30 && !in_ready; t++) begin
        @(posedge clk); #1;
      end
      @(posedge clk);
      acc_t[i] = $time;
      #1;
    end
    in_valid = 1'b0;
    check("b2b_gap_0", 64'((acc_t[1] - acc_t[0]) / 10), 64'(NSLICE + 2));
    check("b2b_gap_1", 64'((acc_t[2] - acc_t[1]) / 10), 64'(NSLICE + 2));
    wait_done(lat);
    check("b2b_last_sum", 64'(result), 64'h1FFFE);
    @(posedge clk); #1;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    sub = 1'b1;
    issue(16'h0005, 16'h0007);
    wait_done(lat);
    check("sub_borrow", 64'(result), 64'h0FFFE);
    @(posedge clk); #1;
    issue(16'h0007, 16'h0005);
    wait_done(lat);
    check("sub_noborrow", 64'(result), 64'h10002);
    @(posedge clk); #1;
    sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands with one shared 4-bit ripple adder slice.
- Processes one nibble per cycle, LSB nibble first, and carries between nibbles in an internal carry flop.
- Sits between a producer and a consumer, each with a valid/ready handshake.
- Sized for area-constrained datapaths where a full-width adder is not wanted.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. Compile-time check required.
- NSLICE, WIDTH/4 (derived localparam, not overridable), number of nibble steps per operation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has operands on a/b.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH+1  sum; bit WIDTH is the final carry.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state goes to IDLE; step counter, carry flop, operand shift registers and result register all clear to 0.
  - Outputs: in_ready=1 after reset release, out_valid=0, result=0, busy=0.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready: capture a/b into shift registers, carry=0, step=0, go to RUN.
  - result keeps its last value until the next operation's first RUN edge.
- RUN, each cycle:
  - s = a_sh[3:0] + b_sh[3:0] + carry, computed 5 bits wide.
  - The result register shifts right by 4 and s[3:0] enters bits [WIDTH-1:WIDTH-4].
  - carry <= s[4]; a_sh and b_sh shift right by 4; step++.
  - On the edge where step==NSLICE-1: result[WIDTH] <= s[4], go to DONE.
- DONE: hold result and out_valid until out_ready, then go to IDLE on that edge.
- Latency: if acceptance happens on edge k, out_valid is high after edge k+NSLICE (4 edges for WIDTH=16).
- Minimum issue interval is NSLICE+2 cycles. There is no accept in the same cycle as DONE->IDLE, because in_ready is 0 in DONE.
- in_valid while busy is ignored; a/b may change freely. Operands are sampled only at acceptance.
- out_ready outside DONE is ignored.
- Wrap-around: all-ones + 1 produces result = {1'b1, WIDTH'b0}. The carry chain must propagate across every step.
- Width rule: result is exactly WIDTH+1 bits with no truncation. Each slice add is 4+4+1 bits into 5 bits.
- Reset asserted mid-RUN or in DONE:
  - The operation is aborted and no out_valid pulse is produced.
  - After release the block is in IDLE with in_ready=1.
- Result register updates only in RUN; between operations it holds the last completed sum.

Optional Feature:
- Macro: NIBBLE_ADD_SEQ_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with a/b at acceptance.
  - If sub=1: b is inverted at capture, the carry flop initialises to 1, and result = a - b as a WIDTH-bit two's-complement value.
  - result[WIDTH] is the not-borrow flag: 1 when a>=b unsigned.
  - If sub=0: behaviour is identical to the non-macro build.
- When undefined: there is no sub port and the block is add-only. Port list, timing and latency are otherwise unchanged.

Test Plan:
- Reset, then a=16'h1234, b=16'h4321, in_valid for one cycle, out_ready=1 -> out_valid is high exactly 4 edges after acceptance with result=17'h05555; in_ready returns to 1 one cycle later.
- a=16'hFFFF, b=16'h0001 -> result=17'h10000. Checks that the carry crosses every nibble boundary.
- a=16'h0F0F, b=16'h00F1, out_ready held 0 for 5 cycles -> out_valid and result=17'h01000 stay stable. in_valid with new operands during the stall is ignored; in_ready=0 throughout.
- Accept a=16'hAAAA, b=16'h5555, assert rst_n=0 on the 2nd RUN cycle -> all outputs cleared immediately, no out_valid pulse; the next operation 16'h0001+16'h0001 gives 17'h00002.
- Back-to-back: hold in_valid=1 with out_ready=1 across three operations -> acceptances are spaced NSLICE+2=6 cycles apart and each result matches the reference sum.
- With NIBBLE_ADD_SEQ_SUB_EN:
  - sub=1, a=16'h0005, b=16'h0007 -> result=17'h0FFFE (not-borrow=0).
  - sub=1, a=16'h0007, b=16'h0005 -> result=17'h10002.
